// File: rtl/pixel_mem_arbiter.sv
// pixel_mem_arbiter
// Owns port B of the R/G/B pixel memories and the 1-bit cluster-ID memory.
// Three requesters share one registered address/write bus: the VGA display
// path, the clustering engine (cluster-ID read/modify/write) and an internal
// clear sequencer that sets every cluster-ID bit to 1.
//
// Optional feature macro: PIXARB_STARVE_GUARD_EN
//   undefined : strict display priority, the engine may starve indefinitely
//   defined   : after STARVE_MAX consecutive engine denials the engine is
//               granted over the display for one cycle
//
// Handshake: a requester holds req (and its address/data) high; the access is
// taken in the cycle where its gnt is high (gnt is combinational from req and
// state). Read data returns exactly two cycles later, qualified by a one-cycle
// rvalid; the data outputs are only meaningful while that rvalid is high.
// Engine writes produce no rvalid.

module pixel_mem_arbiter #(
   parameter int ADDR_W     = 16,
   parameter int NUM_PIX    = 40000
`ifdef PIXARB_STARVE_GUARD_EN
   ,
   parameter int STARVE_MAX = 15
`endif
) (
   input  logic              clk,
   input  logic              reset,

   input  logic              clr_start,
   output logic              clr_busy,
   output logic              clr_done,

   input  logic              disp_req,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic              disp_gnt,
   output logic              disp_rvalid,
   output logic [7:0]        disp_r,
   output logic [7:0]        disp_g,
   output logic [7:0]        disp_b,
   output logic              disp_cid,

   input  logic              eng_req,
   input  logic              eng_we,
   input  logic [ADDR_W-1:0] eng_addr,
   input  logic              eng_cid_wdata,
   output logic              eng_gnt,
   output logic              eng_rvalid,
   output logic [7:0]        eng_r,
   output logic [7:0]        eng_g,
   output logic [7:0]        eng_b,
   output logic              eng_cid,

   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_cid_we,
   output logic              mem_cid_dout,
   input  logic [7:0]        mem_r_din,
   input  logic [7:0]        mem_g_din,
   input  logic [7:0]        mem_b_din,
   input  logic              mem_cid_din,

   output logic [1:0]        state_dbg
);

   // Controller states
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_CLEAR = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   // Owner tags carried alongside each read through the memory latency
   localparam logic [1:0] TAG_NONE = 2'd0;
   localparam logic [1:0] TAG_DISP = 2'd1;
   localparam logic [1:0] TAG_ENG  = 2'd2;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIX - 1);

   logic [1:0]        state;
   logic [1:0]        state_nxt;
   logic [ADDR_W-1:0] clr_cnt;
   logic [1:0]        tag_s1;
   logic [1:0]        tag_s2;
   logic              idle;
   logic              arb_en;
   logic              eng_force;
   logic              eng_rd_gnt;
   logic              eng_wr_gnt;

   assign idle      = (state == ST_IDLE);
   assign state_dbg = state;
   assign clr_busy  = (state == ST_CLEAR);
   assign clr_done  = (state == ST_DONE);

   // Arbitration is only open in IDLE, out of reset, and not in the cycle
   // that launches a clear.
   assign arb_en = reset && idle && !clr_start;

`ifdef PIXARB_STARVE_GUARD_EN
   localparam int SW = ($clog2(STARVE_MAX + 1) > 4) ? $clog2(STARVE_MAX + 1) : 4;
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

   logic [SW-1:0] starve_cnt;

   assign eng_force = (starve_cnt >= STARVE_LIM);

   // Count consecutive IDLE cycles where the engine asked and was refused
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         starve_cnt <= '0;
      end else if (eng_gnt) begin
         starve_cnt <= '0;
      end else if (idle && eng_req && (starve_cnt < STARVE_LIM)) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end
`else
   assign eng_force = 1'b0;
`endif

   // Grants: display first unless the starvation guard forces the engine
   always_comb begin
      disp_gnt = arb_en && disp_req && !(eng_force && eng_req);
      eng_gnt  = arb_en && eng_req && (!disp_req || eng_force);
   end

   assign eng_rd_gnt = eng_gnt && !eng_we;
   assign eng_wr_gnt = eng_gnt && eng_we;

   // Next-state logic for the clear sequencer
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (clr_start) state_nxt = ST_CLEAR;
         ST_CLEAR: if (clr_cnt == LAST_ADDR) state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Clear address counter: loads 0 on launch, advances once per clear write
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         clr_cnt <= '0;
      end else if (idle && clr_start) begin
         clr_cnt <= '0;
      end else if (state == ST_CLEAR) begin
         clr_cnt <= clr_cnt + 1'b1;
      end
   end

   // Shared memory bus; the address holds its last value when idle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_addr     <= '0;
         mem_cid_we   <= 1'b0;
         mem_cid_dout <= 1'b0;
      end else begin
         mem_cid_we   <= 1'b0;
         mem_cid_dout <= 1'b0;
         if (state == ST_CLEAR) begin
            mem_addr     <= clr_cnt;
            mem_cid_we   <= 1'b1;
            mem_cid_dout <= 1'b1;
         end else if (disp_gnt) begin
            mem_addr <= disp_addr;
         end else if (eng_gnt) begin
            mem_addr     <= eng_addr;
            mem_cid_we   <= eng_wr_gnt;
            mem_cid_dout <= eng_wr_gnt && eng_cid_wdata;
         end
      end
   end

   // Two-stage owner tag: stage 1 lines up with the address, stage 2 with data
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tag_s1 <= TAG_NONE;
         tag_s2 <= TAG_NONE;
      end else begin
         if (disp_gnt) begin
            tag_s1 <= TAG_DISP;
         end else if (eng_rd_gnt) begin
            tag_s1 <= TAG_ENG;
         end else begin
            tag_s1 <= TAG_NONE;
         end
         tag_s2 <= tag_s1;
      end
   end

   // Return path: data is a straight pass-through, rvalid picks the owner
   always_comb begin
      disp_rvalid = (tag_s2 == TAG_DISP);
      eng_rvalid  = (tag_s2 == TAG_ENG);
      disp_r      = mem_r_din;
      disp_g      = mem_g_din;
      disp_b      = mem_b_din;
      disp_cid    = mem_cid_din;
      eng_r       = mem_r_din;
      eng_g       = mem_g_din;
      eng_b       = mem_b_din;
      eng_cid     = mem_cid_din;
   end

`ifndef SYNTHESIS
   // At most one requester owns the bus in any cycle
   always @(posedge clk) begin
      if (reset) begin
         assert (!(disp_gnt && eng_gnt));
      end
   end
`endif

endmodule
